// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// A request is accepted only in IDLE. Writes take one RAM cycle. Reads take an
// issue cycle and a capture cycle, and the read result is returned with a
// one-cycle RVALID pulse. Every output comes straight from a flop.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0,
    input  logic                  WE0,
    input  logic [ADDR_WIDTH-1:0] ADDR0,
    input  logic [DATA_WIDTH-1:0] WDATA0,
    output logic                  GNT0,
    output logic                  RVALID0,
    output logic [DATA_WIDTH-1:0] RDATA0,
    input  logic                  REQ1,
    input  logic                  WE1,
    input  logic [ADDR_WIDTH-1:0] ADDR1,
    input  logic [DATA_WIDTH-1:0] WDATA1,
    output logic                  GNT1,
    output logic                  RVALID1,
    output logic [DATA_WIDTH-1:0] RDATA1,
    output logic                  RAM_EN,
    output logic                  RAM_WE,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic [DATA_WIDTH-1:0] RAM_DIN,
    input  logic [DATA_WIDTH-1:0] RAM_DOUT,
    output logic                  BUSY
);

    typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_CAPTURE} state_t;

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic                  win_q, win_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  accept;

    logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                  ram_en_q, ram_en_d, ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
    logic                  busy_q, busy_d;

    // State and latched-request registers; last-grant resets to 1 so requester 0 wins first
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic: arbitrate in IDLE and latch the winner's request
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    accept  = 1'b1;
                    win_d   = (REQ0 && REQ1) ? ~last_q : REQ1;
                    last_d  = win_d;
                    we_d    = win_d ? WE1 : WE0;
                    addr_d  = win_d ? ADDR1 : ADDR0;
                    wdata_d = win_d ? WDATA1 : WDATA0;
                    state_d = we_d ? WR : RD_ISSUE;
                end
            end
            WR:         state_d = IDLE;
            RD_ISSUE:   state_d = RD_CAPTURE;
            RD_CAPTURE: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Output logic: outputs are decoded from the next state so the flops present them in that state
    always_comb begin
        gnt0_d     = accept && !win_d;
        gnt1_d     = accept && win_d;
        rvalid0_d  = (state_q == RD_CAPTURE) && !win_q;
        rvalid1_d  = (state_q == RD_CAPTURE) && win_q;
        rdata0_d   = rvalid0_d ? RAM_DOUT : rdata0_q;
        rdata1_d   = rvalid1_d ? RAM_DOUT : rdata1_q;
        ram_en_d   = (state_d != IDLE);
        ram_we_d   = (state_d == WR);
        ram_addr_d = (state_d != IDLE) ? addr_d : '0;
        ram_din_d  = (state_d == WR) ? wdata_d : '0;
        busy_d     = (state_d != IDLE);
    end

    // Output registers; reset clears them asynchronously, aborting any RAM access
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            busy_q     <= busy_d;
        end
    end

    assign GNT0     = gnt0_q;
    assign GNT1     = gnt1_q;
    assign RVALID0  = rvalid0_q;
    assign RVALID1  = rvalid1_q;
    assign RDATA0   = rdata0_q;
    assign RDATA1   = rdata1_q;
    assign RAM_EN   = ram_en_q;
    assign RAM_WE   = ram_we_q;
    assign RAM_ADDR = ram_addr_q;
    assign RAM_DIN  = ram_din_q;
    assign BUSY     = busy_q;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, RAM address width.
REQ-002 Parameter DATA_WIDTH, default 10, RAM data width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
REQ-004 For each requester n in {0,1}, the block SHALL have these ports:
- REQn  input  1  access request, held until granted.
- WEn  input  1  1 = write, 0 = read; stable while REQn high.
- ADDRn  input  ADDR_WIDTH  access address; stable while REQn high.
- WDATAn  input  DATA_WIDTH  write data; stable while REQn high.
- GNTn  output  1  one-cycle pulse: request accepted.
- RVALIDn  output  1  one-cycle pulse: RDATAn holds read result.
- RDATAn  output  DATA_WIDTH  read data, held until the next read by requester n.
REQ-005 The block SHALL have these RAM-side ports:
- RAM_EN  output  1  RAM enable.
- RAM_WE  output  1  RAM write enable.
- RAM_ADDR  output  ADDR_WIDTH  RAM address.
- RAM_DIN  output  DATA_WIDTH  RAM write data.
- RAM_DOUT  input  DATA_WIDTH  RAM read data; valid only while RAM_EN=1 and RAM_WE=0, one cycle after the address is presented.
- BUSY  output  1  high in any state other than IDLE.

Function
REQ-006 The FSM SHALL have four states: IDLE, WR, RD_ISSUE, RD_CAPTURE. All outputs SHALL be registered.
REQ-007 In IDLE with any REQn high at a rising edge, the block SHALL:
- select a winner;
- latch the winner's WE, ADDR and WDATA;
- pulse the winner's GNTn for the next cycle;
- enter WR if WE=1, else RD_ISSUE.
REQ-008 When both REQ0 and REQ1 are high in IDLE, the block SHALL grant the requester not granted most recently (round-robin on a last-grant bit).
REQ-009 When only one REQ is high, the block SHALL grant that requester regardless of the last-grant bit, and SHALL update the last-grant bit on every grant.
REQ-010 In WR, the block SHALL drive RAM_EN=1, RAM_WE=1, RAM_ADDR/RAM_DIN = latched values, then return to IDLE (write cost: 2 cycles, request edge to IDLE).
REQ-011 In RD_ISSUE, the block SHALL drive RAM_EN=1, RAM_WE=0, RAM_ADDR = latched address, then go to RD_CAPTURE.
REQ-012 In RD_CAPTURE, the block SHALL hold RAM_EN=1, RAM_WE=0 and the same RAM_ADDR, and SHALL capture RAM_DOUT into the winner's RDATAn at the closing edge.
REQ-013 After RD_CAPTURE, the block SHALL return to IDLE and pulse RVALIDn with RDATAn in that IDLE cycle (read latency: RVALID 3 cycles after the request edge).
REQ-014 In IDLE, the block SHALL drive RAM_EN=0, RAM_WE=0, RAM_ADDR=0, RAM_DIN=0; in read states, RAM_DIN SHALL be 0.
REQ-015 The block SHALL accept at most one request per IDLE visit and SHALL NOT grant while BUSY; any requests pending in other states wait.
REQ-016 A REQn still high in the IDLE cycle after its GNTn pulse SHALL be treated as a new request. Requesters deassert REQn at the edge where they sample GNTn=1.
REQ-017 The block SHALL accept a new request in the same IDLE cycle in which RVALID is pulsed; GNT and RVALID to different or the same requester may coincide.
REQ-018 RDATAn of the non-winning requester SHALL remain unchanged.
REQ-019 Address and data SHALL pass through unmodified, with no width conversion; all 2^ADDR_WIDTH addresses are legal, including 0 and the maximum.

Reset
REQ-020 On RST high, the block SHALL immediately enter IDLE and drive all outputs to 0, including RDATA0/1, GNTn, RVALIDn, RAM_* and BUSY.
REQ-021 On reset, the last-grant bit SHALL be set to 1, so requester 0 wins the first contested arbitration.
REQ-022 RST asserted mid-operation SHALL:
- abort the access immediately, with RAM_EN falling asynchronously;
- produce no GNT or RVALID for the aborted access;
- leave the RAM contents at the aborted write address undefined.
REQ-023 The block SHALL NOT reset or initialise RAM contents.

Verification
REQ-024 Write then read: REQ0 write 0x3FF at 0x00, then REQ0 read 0x00 -> GNT0 pulses twice; RVALID0=1 with RDATA0=0x3FF exactly 3 cycles after the read request edge.
REQ-025 Contention: REQ0 and REQ1 both reading after reset -> GNT0 first, then GNT1; on continued contention, grants alternate 0,1,0,1.
REQ-026 Single requester: REQ1 only, repeated writes to addresses 0xFF, 0x80, 0x01 -> each granted, never starved, with RAM_WE=1 for exactly one cycle each.
REQ-027 Mid-read reset: RST pulsed during RD_CAPTURE -> all outputs 0 asynchronously; no RVALID; state IDLE; next request proceeds normally.
REQ-028 Isolation: REQ0 reads 0x10 (=0x155) while RDATA1 holds 0x2AA -> RDATA1 stays 0x2AA; RVALID1 stays 0.
